reorder_buffer: RTL

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 44 ++++
 rtl/reorder_buffer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared dispatch/ROB types and pointer helper. `ROB_SIZE sets the default ROB depth.
`ifndef ROB_SIZE
`define ROB_SIZE 8
`endif

package reorder_buffer_pkg;

  typedef logic [4:0]  Register;
  typedef logic [31:0] MemoryWord;
  typedef logic [4:0]  RobSize;

  typedef struct packed {
    logic regwr;
    logic memwr;
    logic cjump;
    logic ecall;
    logic unsupported;
  } control_bits;

  typedef struct packed {
    logic        busy;
    logic        ready;
    RobSize      tag;
    control_bits ctrl_bits;
    Register     rd;
    MemoryWord   value;
  } rob_entry;

  typedef struct packed {
    RobSize    tag;
    MemoryWord value;
  } cdb;

  typedef struct packed {
    Register   regstr;
    MemoryWord value;
  } Victim;

  // 1-based circular pointer advance, shared with the LSQ
  function automatic logic [31:0] ptr_next(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr == depth) ? 32'd1 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement reorder buffer with dual CDB writeback.
// Define ROB_FLUSH_EN to make the flush input discard all in-flight entries.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = `ROB_SIZE
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rob_increment,
  input  rob_entry  re,
  input  cdb        cdb1,
  input  cdb        cdb2,
  input  logic      flush,
  output rob_entry  rob [DEPTH],
  output int        rob_head,
  output int        rob_tail,
  output int        rob_count,
  output logic      retire_valid,
  output logic      retire_regwr,
  output Register   retire_rd,
  output MemoryWord retire_value,
  output RobSize    retire_tag,
  output logic      store_commit,
  output logic      ecall_retired,
  output Victim     victim
);

  localparam int AW = $clog2(DEPTH);

  rob_entry    slots_q [DEPTH];
  rob_entry    slots_d [DEPTH];
  logic [31:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
  Victim       victim_q, victim_d;
  logic [AW-1:0] head_idx, tail_idx;
  rob_entry    head_e;
  logic        flush_now, do_retire, do_alloc;
  logic [$bits(RobSize):0] unused_re;

`ifdef ROB_FLUSH_EN
  assign flush_now = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_now    = 1'b0;
`endif

  // busy and tag are owned by the ROB, not by dispatch
  assign unused_re = {re.busy, re.tag};

  assign head_idx  = AW'(head_q - 32'd1);
  assign tail_idx  = AW'(tail_q - 32'd1);
  assign head_e    = slots_q[head_idx];
  assign do_retire = head_e.busy && head_e.ready && !flush_now;
  assign do_alloc  = rob_increment && (count_q < 32'(DEPTH)) && !flush_now;

  assign retire_valid  = do_retire;
  assign retire_regwr  = do_retire && head_e.ctrl_bits.regwr && !head_e.ctrl_bits.unsupported
                         && !head_e.ctrl_bits.ecall && (head_e.rd != '0);
  assign store_commit  = do_retire && head_e.ctrl_bits.memwr && !head_e.ctrl_bits.unsupported;
  assign ecall_retired = do_retire && head_e.ctrl_bits.ecall && !head_e.ctrl_bits.unsupported;
  assign retire_rd     = head_e.rd;
  assign retire_value  = head_e.value;
  assign retire_tag    = RobSize'(head_q);

  assign rob       = slots_q;
  assign rob_head  = int'(head_q);
  assign rob_tail  = int'(tail_q);
  assign rob_count = int'(count_q);
  assign victim    = victim_q;

  always_comb begin
    slots_d  = slots_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    victim_d = victim_q;

    // Only slots busy at cycle start listen, so a same-cycle allocation never sees CDB data.
    // cdb1 is applied last so it wins a tag collision.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (slots_q[i].busy) begin
        if (cdb2.tag != '0 && cdb2.tag == slots_q[i].tag) begin
          if (!slots_q[i].ctrl_bits.cjump) slots_d[i].value = cdb2.value;
          slots_d[i].ready = 1'b1;
        end
        if (cdb1.tag != '0 && cdb1.tag == slots_q[i].tag) begin
          if (!slots_q[i].ctrl_bits.cjump) slots_d[i].value = cdb1.value;
          slots_d[i].ready = 1'b1;
        end
      end
    end

    if (do_retire) begin
      slots_d[head_idx].busy  = 1'b0;
      slots_d[head_idx].ready = 1'b0;
      head_d = ptr_next(head_q, DEPTH);
      if (retire_regwr) victim_d = '{regstr: head_e.rd, value: head_e.value};
    end

    if (do_alloc) begin
      slots_d[tail_idx]      = re;
      slots_d[tail_idx].busy = 1'b1;
      slots_d[tail_idx].tag  = RobSize'(tail_q);
      tail_d = ptr_next(tail_q, DEPTH);
    end

    count_d = count_q + {31'b0, do_alloc} - {31'b0, do_retire};

`ifdef ROB_FLUSH_EN
    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slots_d[i]       = slots_q[i];
        slots_d[i].busy  = 1'b0;
        slots_d[i].ready = 1'b0;
      end
      head_d   = 32'd1;
      tail_d   = 32'd1;
      count_d  = '0;
      victim_d = victim_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slots_q[i]     <= '0;
        slots_q[i].tag <= RobSize'(i + 1);
      end
      head_q   <= 32'd1;
      tail_q   <= 32'd1;
      count_q  <= '0;
      victim_q <= '0;
    end else begin
      slots_q  <= slots_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      victim_q <= victim_d;
    end
  end

endmodule
